// File: rtl/dm_arb_pkg.sv
// Shared definitions for the dm_arbiter block: FSM state encoding and port indices.
package dm_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/dm_arb_rsp.sv
// Per-port registered read response: captures mem_dout on a granted read and
// pulses rvalid for the following cycle.
module dm_arb_rsp #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gnt,
    input  logic          we,
    input  logic [DW-1:0] mem_dout,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= gnt & ~we;
            // rdata holds between reads so late consumers still see the last word
            if (gnt && !we) begin
                rdata <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data memory.
// Optional p1 exclusive-lock mode is compiled in when DM_ARB_LOCK_EN is defined.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    input  logic          p1_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic last_q, last_d;
    logic locked;

`ifdef DM_ARB_LOCK_EN
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    assign locked = (state_q == LOCK1);
`else
    logic unused_lock;

    assign locked      = 1'b0;
    assign unused_lock = p1_lock ^ (MAX_LOCK == 0);
`endif

    // Grants are purely combinational and forced low during reset.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (locked) begin
                p1_gnt = p1_req;
            end else if (p0_req && p1_req) begin
                p0_gnt = (last_q == P1);
                p1_gnt = (last_q == P0);
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    assign mem_we   = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    assign mem_addr = p1_gnt ? p1_addr  : p0_addr;
    assign mem_din  = p1_gnt ? p1_wdata : p0_wdata;

`ifdef DM_ARB_LOCK_EN
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        if (p0_gnt) begin
            last_d = P0;
        end else if (p1_gnt) begin
            last_d = P1;
        end
        case (state_q)
            ARB: begin
                // A single-grant lock limit means the entry grant already exhausts it.
                if (p1_gnt && p1_lock && (MAX_LOCK > 1)) begin
                    state_d    = LOCK1;
                    lock_cnt_d = CW'(1);
                end
            end
            LOCK1: begin
                if (p1_gnt) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
                if (!p1_req || !p1_lock || (p1_gnt && (lock_cnt_d == CW'(MAX_LOCK)))) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    last_d     = P1;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
            last_q     <= P1;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
        end
    end
`else
    always_comb begin
        last_d = last_q;
        if (p0_gnt) begin
            last_d = P0;
        end else if (p1_gnt) begin
            last_d = P1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= P1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    dm_arb_rsp #(
        .DW(DW)
    ) u_rsp_p0 (
        .clk     (clk),
        .rst     (rst),
        .gnt     (p0_gnt),
        .we      (p0_we),
        .mem_dout(mem_dout),
        .rvalid  (p0_rvalid),
        .rdata   (p0_rdata)
    );

    dm_arb_rsp #(
        .DW(DW)
    ) u_rsp_p1 (
        .clk     (clk),
        .rst     (rst),
        .gnt     (p1_gnt),
        .we      (p1_we),
        .mem_dout(mem_dout),
        .rvalid  (p1_rvalid),
        .rdata   (p1_rdata)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small memory stand-in and a read-data scoreboard.
// Lock-mode expectations follow DM_ARB_LOCK_EN.
module tb_dm_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    dm_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_LOCK(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_gnt   (p0_gnt),
        .p0_rvalid(p0_rvalid),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_gnt   (p1_gnt),
        .p1_rvalid(p1_rvalid),
        .p1_rdata (p1_rdata),
        .p1_lock  (p1_lock),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return 32'hA5A50000 | 32'(idx);
    endfunction

    // Memory stand-in driven by the DUT's mem_* port.
    logic [31:0] mem [64];
    bit          mem_wr [64];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]]    <= mem_din;
            mem_wr[mem_addr[7:2]] <= 1'b1;
        end
    end

    assign mem_dout = mem_wr[mem_addr[7:2]] ? mem[mem_addr[7:2]] : init_val(int'(mem_addr[7:2]));

    // Reference memory updated only from the bench's own expectations.
    logic [31:0] ref_mem [64];
    bit          ref_wr [64];

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        if (ref_wr[a[7:2]]) return ref_mem[a[7:2]];
        return init_val(int'(a[7:2]));
    endfunction

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp0 = '0;
    logic [31:0] exp1 = '0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag, input string what);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    // One clock: check combinational grant/mem outputs, then the registered response.
    task automatic cycle(input logic e0, input logic e1, input string tag);
        logic ew, ev0, ev1, r;
        #1;
        chk(32'(p0_gnt), 32'(e0), tag, "p0_gnt");
        chk(32'(p1_gnt), 32'(e1), tag, "p1_gnt");
        ew = (e0 & p0_we) | (e1 & p1_we);
        chk(32'(mem_we), 32'(ew), tag, "mem_we");
        if (e0 || e1) begin
            chk(mem_addr, e1 ? p1_addr : p0_addr, tag, "mem_addr");
        end
        if (ew) begin
            chk(mem_din, e1 ? p1_wdata : p0_wdata, tag, "mem_din");
            ref_mem[(e1 ? p1_addr[7:2] : p0_addr[7:2])] = e1 ? p1_wdata : p0_wdata;
            ref_wr[(e1 ? p1_addr[7:2] : p0_addr[7:2])]  = 1'b1;
        end
        ev0 = e0 & ~p0_we;
        ev1 = e1 & ~p1_we;
        if (ev0) q0.push_back(ref_rd(p0_addr));
        if (ev1) q1.push_back(ref_rd(p1_addr));
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            q0.delete();
            q1.delete();
            ev0  = 1'b0;
            ev1  = 1'b0;
            exp0 = '0;
            exp1 = '0;
        end else begin
            if (ev0) exp0 = q0.pop_front();
            if (ev1) exp1 = q1.pop_front();
        end
        chk(32'(p0_rvalid), 32'(ev0), tag, "p0_rvalid");
        chk(p0_rdata, exp0, tag, "p0_rdata");
        chk(32'(p1_rvalid), 32'(ev1), tag, "p1_rvalid");
        chk(p1_rdata, exp1, tag, "p1_rdata");
    endtask

    initial begin
        rst      = 1'b1;
        p0_req   = 1'b1;
        p0_we    = 1'b1;
        p0_addr  = 32'h10;
        p0_wdata = 32'hBAD0BAD0;
        p1_req   = 1'b1;
        p1_we    = 1'b0;
        p1_addr  = 32'h0;
        p1_wdata = 32'h0;
        p1_lock  = 1'b0;

        // Grants and writes gated during reset
        cycle(1'b0, 1'b0, "reset0");
        cycle(1'b0, 1'b0, "reset1");

        rst    = 1'b0;
        p0_we  = 1'b0;
        p1_req = 1'b0;
        cycle(1'b1, 1'b0, "p0_rd10");

        p0_req  = 1'b0;
        p1_req  = 1'b1;
        p1_addr = 32'h20;
        cycle(1'b0, 1'b1, "p1_rd20");

        // Contention: last=p1, so p0 first, then alternating
        p0_req  = 1'b1;
        p0_addr = 32'h08;
        p1_addr = 32'h0C;
        for (int i = 0; i < 6; i++) begin
            cycle((i % 2) == 0, (i % 2) == 1, "rr");
        end

        p1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p0_addr = 32'h18 + 32'(4 * i);
            cycle(1'b1, 1'b0, "b2b");
        end

        p0_req   = 1'b0;
        p1_req   = 1'b1;
        p1_we    = 1'b1;
        p1_addr  = 32'h40;
        p1_wdata = 32'h12345678;
        cycle(1'b0, 1'b1, "p1_wr40");

        p1_req  = 1'b0;
        p1_we   = 1'b0;
        p0_req  = 1'b1;
        p0_addr = 32'h40;
        cycle(1'b1, 1'b0, "p0_rd40");

        // Lock run to MAX_LOCK (last=p0 so p1 wins first)
        p0_addr = 32'h08;
        p1_addr = 32'h0C;
        p1_req  = 1'b1;
        p1_lock = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef DM_ARB_LOCK_EN
            cycle(i == 8, i != 8, "lock_max");
`else
            cycle((i % 2) == 1, (i % 2) == 0, "lock_ign");
`endif
        end

        p1_req  = 1'b0;
        p1_lock = 1'b0;
        cycle(1'b1, 1'b0, "setlast1");

        // Lock dropped after three grants
        p1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p1_lock = (i < 3);
`ifdef DM_ARB_LOCK_EN
            cycle(i == 4, i != 4, "lock_drop");
`else
            cycle((i % 2) == 1, (i % 2) == 0, "lock_drop");
`endif
        end

        p1_req  = 1'b0;
        p1_lock = 1'b0;
        cycle(1'b1, 1'b0, "setlast2");

        // Reset mid-lock with a read in flight
        p1_req  = 1'b1;
        p1_lock = 1'b1;
        cycle(1'b0, 1'b1, "prelock0");
`ifdef DM_ARB_LOCK_EN
        cycle(1'b0, 1'b1, "prelock1");
`else
        cycle(1'b1, 1'b0, "prelock1");
`endif
        rst   = 1'b1;
        p0_we = 1'b1;
        cycle(1'b0, 1'b0, "rst_mid");

        rst     = 1'b0;
        p0_we   = 1'b0;
        p1_lock = 1'b0;
        cycle(1'b1, 1'b0, "post_rst0");
        cycle(1'b0, 1'b1, "post_rst1");

        p0_req = 1'b0;
        p1_req = 1'b0;
        cycle(1'b0, 1'b0, "idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
